// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive-side 4-channel TDM demultiplexer.
// Accepts one serialized sample per valid cycle. The sync strobe marks slot 0.
// Each sample is steered into one of four registered channel outputs.
// A HUNT/LOCKED state machine and a 2-bit slot counter track the frame position.
// Optional feature macro: TDM_SYNC_CHECK_EN. When it is defined, the block adds
// the sticky sync_err flag, and a missing sync sends the block back to HUNT.
module tdm_demux4 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic           in_sync,
    input  logic [W-1:0]   in_data,
    output logic [4*W-1:0] out_data,
    output logic [3:0]     out_valid,
    output logic           frame_done,
    output logic [1:0]     slot,
    output logic           locked
`ifdef TDM_SYNC_CHECK_EN
    ,
    output logic           sync_err
`endif
);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     slot_q, slot_d;
    logic [4*W-1:0] data_q, data_d;
    logic [3:0]     valid_q, valid_d;
    logic           fdone_q, fdone_d;
    logic           cap_s;
    logic [1:0]     cap_ch_s;
`ifdef TDM_SYNC_CHECK_EN
    logic           err_q, err_d;
`endif

    // Next-state sequencing: decide whether this sample is captured, which channel gets it, and the new slot.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        fdone_d  = 1'b0;
        cap_s    = 1'b0;
        cap_ch_s = 2'd0;
`ifdef TDM_SYNC_CHECK_EN
        err_d    = err_q;
`endif
        if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (in_sync) begin
                        cap_s    = 1'b1;
                        cap_ch_s = 2'd0;
                        slot_d   = 2'd1;
                        state_d  = ST_LOCKED;
                    end else begin
                        // The sample arrived before the first sync, so it is discarded.
                        state_d = ST_HUNT;
                        slot_d  = 2'd0;
                    end
                end
                ST_LOCKED: begin
                    if (in_sync) begin
                        // Sync always restarts the frame at slot 0. Channels that the
                        // broken frame never reached keep their old contents.
                        cap_s    = 1'b1;
                        cap_ch_s = 2'd0;
                        slot_d   = 2'd1;
`ifdef TDM_SYNC_CHECK_EN
                        if (slot_q != 2'd0) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
`endif
                    end else if (slot_q == 2'd0) begin
`ifdef TDM_SYNC_CHECK_EN
                        // Sync is missing at the frame boundary: drop the sample and return to HUNT.
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                        slot_d  = 2'd0;
`else
                        // Free-running mode: treat the sample as slot 0 without a sync.
                        cap_s    = 1'b1;
                        cap_ch_s = 2'd0;
                        slot_d   = 2'd1;
`endif
                    end else begin
                        cap_s    = 1'b1;
                        cap_ch_s = slot_q;
                        slot_d   = slot_q + 2'd1;
                        fdone_d  = (slot_q == 2'd3);
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end else begin
            state_d = state_q;
            slot_d  = slot_q;
        end
    end

    // Channel steering: only the addressed channel loads, and the same decision drives its out_valid pulse.
    always_comb begin
        data_d  = data_q;
        valid_d = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (cap_s && (cap_ch_s == 2'(k))) begin
                data_d[k*W +: W] = in_data;
                valid_d[k]       = 1'b1;
            end else begin
                data_d[k*W +: W] = data_q[k*W +: W];
                valid_d[k]       = 1'b0;
            end
        end
    end

    // State, slot counter and all output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            slot_q  <= 2'd0;
            data_q  <= '0;
            valid_q <= 4'b0000;
            fdone_q <= 1'b0;
`ifdef TDM_SYNC_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fdone_q <= fdone_d;
`ifdef TDM_SYNC_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign frame_done = fdone_q;
    assign slot       = slot_q;
    assign locked     = (state_q == ST_LOCKED);
`ifdef TDM_SYNC_CHECK_EN
    assign sync_err   = err_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Testbench for tdm_demux4 with W=8. It runs a table of single-cycle vectors,
// then hand-written resync, missing-sync and asynchronous-reset sequences,
// then randomized traffic that is compared against a frame-level reference model.
module tb_tdm_demux4;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_sync;
    logic [W-1:0]   in_data;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_valid;
    logic           frame_done;
    logic [1:0]     slot;
    logic           locked;
`ifdef TDM_SYNC_CHECK_EN
    logic           sync_err;
`endif

    int total;
    int bad;

    tdm_demux4 #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sync    (in_sync),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .slot       (slot),
        .locked     (locked)
`ifdef TDM_SYNC_CHECK_EN
        ,
        .sync_err   (sync_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic [31:0] ed;
        logic [3:0]  ev;
        logic        ef;
        logic [1:0]  es;
        logic        el;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic s, input logic [7:0] d,
                                input logic [31:0] ed, input logic [3:0] ev,
                                input logic ef, input logic [1:0] es, input logic el);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.ed = ed; r.ev = ev; r.ef = ef; r.es = es; r.el = el;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one input cycle on the falling edge, then settle just after the next rising edge.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [31:0] ed, input logic [3:0] ev,
                           input logic ef, input logic [1:0] es, input logic el);
        chk({nm, "_data"},   64'(out_data),   64'(ed));
        chk({nm, "_valid"},  64'(out_valid),  64'(ev));
        chk({nm, "_fdone"},  64'(frame_done), 64'(ef));
        chk({nm, "_slot"},   64'(slot),       64'(es));
        chk({nm, "_locked"}, 64'(locked),     64'(el));
    endtask

    // Frame-level reference model. pos is -1 while hunting; otherwise it is the next slot.
    int         m_pos;
    logic [7:0] m_ch [4];
    logic       m_err;
    logic [3:0] m_ov;
    logic       m_fd;

    function automatic void model_reset();
        m_pos = -1;
        for (int k = 0; k < 4; k++) m_ch[k] = 8'h00;
        m_err = 1'b0;
        m_ov  = 4'b0000;
        m_fd  = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic s, input logic [7:0] d);
        m_ov = 4'b0000;
        m_fd = 1'b0;
        if (v) begin
            if (m_pos < 0) begin
                if (s) begin
                    m_ch[0] = d; m_ov[0] = 1'b1; m_pos = 1;
                end
            end else if (s) begin
                if (m_pos != 0) m_err = 1'b1;
                m_ch[0] = d; m_ov[0] = 1'b1; m_pos = 1;
            end else begin
`ifdef TDM_SYNC_CHECK_EN
                if (m_pos == 0) begin
                    m_err = 1'b1;
                    m_pos = -1;
                end else begin
`else
                begin
`endif
                    m_ch[m_pos] = d;
                    m_ov[m_pos] = 1'b1;
                    m_fd        = (m_pos == 3);
                    m_pos       = (m_pos + 1) % 4;
                end
            end
        end
    endfunction

    initial begin
        logic [31:0] exp_data;
        logic        rv;
        logic        rs;
        logic [7:0]  rd;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = 8'h00;

        // Hold reset while driving random inputs; every output must stay cleared.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_sync  = 1'($urandom);
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
            chk_all("reset", 32'h0, 4'h0, 1'b0, 2'd0, 1'b0);
`ifdef TDM_SYNC_CHECK_EN
            chk("reset_err", 64'(sync_err), 64'd0);
`endif
        end
        @(negedge clk);
        rst = 1'b0;

        // Table: hunt discard, a frame with 3-cycle gaps, then a back-to-back frame.
        tbl.push_back(mk(1'b1, 1'b0, 8'hAA, 32'h00000000, 4'h0, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 8'hBB, 32'h00000000, 4'h0, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 8'h01, 32'h00000001, 4'h1, 1'b0, 2'd1, 1'b1));
        for (int g = 0; g < 3; g++) tbl.push_back(mk(1'b0, 1'b1, 8'hEE, 32'h00000001, 4'h0, 1'b0, 2'd1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 8'h22, 32'h00002201, 4'h2, 1'b0, 2'd2, 1'b1));
        for (int g = 0; g < 3; g++) tbl.push_back(mk(1'b0, 1'b0, 8'hEE, 32'h00002201, 4'h0, 1'b0, 2'd2, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 8'h33, 32'h00332201, 4'h4, 1'b0, 2'd3, 1'b1));
        for (int g = 0; g < 3; g++) tbl.push_back(mk(1'b0, 1'b0, 8'hEE, 32'h00332201, 4'h0, 1'b0, 2'd3, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 8'h44, 32'h44332201, 4'h8, 1'b1, 2'd0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 8'h11, 32'h44332211, 4'h1, 1'b0, 2'd1, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 8'h22, 32'h44332211, 4'h2, 1'b0, 2'd2, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 8'h33, 32'h44332211, 4'h4, 1'b0, 2'd3, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 8'h44, 32'h44332211, 4'h8, 1'b1, 2'd0, 1'b1));
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d);
            chk_all($sformatf("row%0d", i), tbl[i].ed, tbl[i].ev, tbl[i].ef, tbl[i].es, tbl[i].el);
        end
`ifdef TDM_SYNC_CHECK_EN
        chk("table_err", 64'(sync_err), 64'd0);
`endif

        // Resync: the frame breaks after slot 2; ch3 keeps 0x44.
        step(1'b1, 1'b1, 8'hA0);
        step(1'b1, 1'b0, 8'h10);
        step(1'b1, 1'b0, 8'h20);
        step(1'b1, 1'b1, 8'h99);
        chk_all("resync", 32'h44201099, 4'h1, 1'b0, 2'd1, 1'b1);
`ifdef TDM_SYNC_CHECK_EN
        chk("resync_err", 64'(sync_err), 64'd1);
`endif
        step(1'b1, 1'b0, 8'h21);
        step(1'b1, 1'b0, 8'h31);
        step(1'b1, 1'b0, 8'h41);
        chk_all("refill", 32'h41312199, 4'h8, 1'b1, 2'd0, 1'b1);

        // Missing sync at the frame boundary.
        step(1'b1, 1'b0, 8'h77);
`ifdef TDM_SYNC_CHECK_EN
        chk_all("missing", 32'h41312199, 4'h0, 1'b0, 2'd0, 1'b0);
        chk("missing_err", 64'(sync_err), 64'd1);
`else
        chk_all("missing", 32'h41312177, 4'h1, 1'b0, 2'd1, 1'b1);
`endif

        // Asynchronous reset mid-frame clears outputs before any clock edge.
        step(1'b1, 1'b1, 8'h12);
        step(1'b1, 1'b0, 8'h34);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("async_rst", 32'h0, 4'h0, 1'b0, 2'd0, 1'b0);
`ifdef TDM_SYNC_CHECK_EN
        chk("async_rst_err", 64'(sync_err), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h56);
        chk_all("post_rst_nosync", 32'h0, 4'h0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b1, 8'h78);
        chk_all("post_rst_sync", 32'h00000078, 4'h1, 1'b0, 2'd1, 1'b1);

        // Randomized traffic against the reference model.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(3, 0) != 0);
            rs = ($urandom_range(5, 0) == 0);
            rd = 8'($urandom);
            step(rv, rs, rd);
            model_step(rv, rs, rd);
            exp_data = {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
            chk_all($sformatf("rnd%0d", i), exp_data, m_ov, m_fd,
                    (m_pos < 0) ? 2'd0 : 2'(m_pos), (m_pos >= 0));
`ifdef TDM_SYNC_CHECK_EN
            chk($sformatf("rnd%0d_err", i), 64'(sync_err), 64'(m_err));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
